// File: rtl/playback_pkg.sv
// Shared encodings and default sizes for the audio playback sequencer.
package playback_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_PAUSE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int DEF_TICK_DIV = 4194304;
    localparam int DEF_LEN0     = 512;
    localparam int DEF_LEN1     = 576;
    // Divider the note path loads to force an inaudible output.
    localparam int SILENCE_DIV  = 50000000;

endpackage

// File: rtl/playback_sequencer_tick.sv
// Beat divider: tick is high in the cycle the counter wraps from TICK_DIV-1.
// The counter only advances while run is high; clear zeroes it and has priority over run.
module beat_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] tick_cnt;

    assign tick = run && (tick_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
        end else if (run) begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/playback_sequencer.sv
// Single-clock beat scheduler: play/pause, repeat with silent gap, end-of-track and track skip.
// Beat index, track select and silence feed the music ROM and the note-generation path.
module playback_sequencer
    import playback_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int LEN0      = DEF_LEN0,
    parameter int LEN1      = DEF_LEN1,
    parameter int GAP_BEATS = 4,
    parameter int BW        = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          play_en,
    input  logic          repeat_en,
    input  logic          track_sel,
    input  logic          next_pulse,
    output logic [BW-1:0] ibeat,
    output logic          track,
    output logic          silence,
    output logic          beat_tick,
    output logic          done
);
    localparam int GW = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;
    localparam logic [BW-1:0] LAST0 = BW'(LEN0 - 1);
    localparam logic [BW-1:0] LAST1 = BW'(LEN1 - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_BEATS > 0) ? GAP_BEATS - 1 : 0);

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          track_sel_q;
    logic          chg, nxt, active, run, clear, tick;
    logic [BW-1:0] last;

    assign chg    = (track_sel != track_sel_q);
    assign nxt    = next_pulse && (state == S_PLAY || state == S_PAUSE || state == S_GAP);
    assign active = (state == S_PLAY || state == S_GAP);
    // Higher-priority events in the same cycle swallow the tick.
    assign run    = active && play_en && !chg && !nxt;
    assign clear  = chg || nxt || state == S_IDLE || state == S_DONE;
    assign last   = track ? LAST1 : LAST0;

    beat_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ibeat       <= '0;
            track       <= 1'b0;
            gap_cnt     <= '0;
            track_sel_q <= 1'b0;
            silence     <= 1'b1;
            beat_tick   <= 1'b0;
            done        <= 1'b0;
        end else begin
            track_sel_q <= track_sel;
            beat_tick   <= 1'b0;
            done        <= 1'b0;
            if (chg || nxt) begin
                track <= chg ? track_sel : ~track;
                ibeat <= '0;
                if (state == S_GAP) begin
                    state   <= S_PLAY;
                    silence <= 1'b0;
                end else if (state == S_DONE) begin
                    state   <= S_IDLE;
                    silence <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: if (play_en) begin
                        state   <= S_PLAY;
                        ibeat   <= '0;
                        silence <= 1'b0;
                    end
                    S_PLAY: if (!play_en) begin
                        state   <= S_PAUSE;
                        silence <= 1'b1;
                    end else if (tick) begin
                        beat_tick <= 1'b1;
                        if (ibeat != last) begin
                            ibeat <= ibeat + BW'(1);
                        end else begin
                            ibeat <= '0;
                            if (!repeat_en) begin
                                state   <= S_DONE;
                                silence <= 1'b1;
                                done    <= 1'b1;
                            end else if (GAP_BEATS > 0) begin
                                state   <= S_GAP;
                                silence <= 1'b1;
                                gap_cnt <= GAP_LOAD;
                            end
                        end
                    end
                    S_PAUSE: if (play_en) begin
                        state   <= S_PLAY;
                        silence <= 1'b0;
                    end
                    // ibeat is already 0 here, so a pause during the gap resumes at beat 0.
                    S_GAP: if (!play_en) begin
                        state <= S_PAUSE;
                    end else if (tick) begin
                        if (gap_cnt == '0) begin
                            state   <= S_PLAY;
                            silence <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - GW'(1);
                        end
                    end
                    S_DONE: if (!play_en) begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state   <= S_IDLE;
                        silence <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/playback_sequencer.md
Name: playback_sequencer

Overview:
Controls the beat counter for the audio player. It replaces the slow-clock player control with a single-clock scheduler. Every beat is derived from the system clock by an internal tick divider. The block sequences two tracks of different length through play, pause, repeat-with-gap, end-of-track and track-skip. Its outputs are the beat index and track select for the music ROM, and a silence flag that the note-generation path uses to force the silent divider.

Parameters:
TICK_DIV, 4194304, system-clock cycles per beat; legal range is 2 or more.
LEN0, 512, beats in track 0.
LEN1, 576, beats in track 1.
GAP_BEATS, 4, silent beats inserted between repeats; 0 means no gap.
BW, 12, width of the beat index; LEN0 and LEN1 must be at most 2^BW.

Ports:
clk  in  1  system clock from the crystal.
rst  in  1  asynchronous, active-high reset; clears all state immediately.
play_en  in  1  level input; 1 means play, 0 means pause. Synchronous to clk.
repeat_en  in  1  level input; sampled only at end of track.
track_sel  in  1  level input; track requested by the switch.
next_pulse  in  1  one-cycle pulse, already debounced; skip to the other track.
ibeat  out  BW  current beat index.
track  out  1  track currently being sequenced.
silence  out  1  1 whenever state is not PLAY.
beat_tick  out  1  one-cycle pulse at every beat boundary while in PLAY.
done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset values: state=IDLE, ibeat=0, track=0, tick_cnt=0, gap_cnt=0, silence=1, beat_tick=0, done=0, track_sel_q=0.
- All outputs are registered. len = track ? LEN1 : LEN0.
- Tick divider:
  - tick_cnt advances only in PLAY and GAP.
  - beat_tick=1 in the cycle where tick_cnt wraps from TICK_DIV-1 to 0.
  - tick_cnt holds in PAUSE. It clears in IDLE, in DONE, and on any track change.
- States: IDLE, PLAY, PAUSE, GAP, DONE.
  - IDLE: play_en=1 moves to PLAY on the next cycle with ibeat=0.
  - PLAY, on a tick with ibeat<len-1: ibeat increments.
  - PLAY, on a tick with ibeat==len-1:
    - repeat_en=1 and GAP_BEATS>0: go to GAP, ibeat=0, gap_cnt=GAP_BEATS-1.
    - repeat_en=1 and GAP_BEATS=0: stay in PLAY, ibeat=0.
    - repeat_en=0: go to DONE, ibeat=0, done=1 for one cycle.
  - PLAY, play_en=0: go to PAUSE. ibeat and tick_cnt are frozen. A tick in that same cycle is suppressed.
  - PAUSE, play_en=1: go to PLAY and resume from the frozen ibeat and tick_cnt.
  - GAP: each tick decrements gap_cnt. The tick at gap_cnt==0 moves to PLAY. play_en=0 during GAP moves to PAUSE; resume then returns to PLAY at ibeat=0, and the remaining gap is dropped.
  - DONE: play_en=0 moves to IDLE. Staying in DONE with play_en=1 does not restart; a 0 then 1 cycle of play_en is required.
- Track change: track_sel differs from track_sel_q. track_sel_q is updated every cycle.
  - Applies in any state: track <= track_sel, ibeat=0, tick_cnt=0.
  - PLAY and PAUSE keep their state. GAP goes to PLAY. DONE goes to IDLE.
- next_pulse, in PLAY, PAUSE or GAP only: track <= ~track, ibeat=0, tick_cnt=0, and the state is handled exactly as for a track change. next_pulse is ignored in IDLE and DONE.
- Priority within a cycle: rst, then track change, then next_pulse, then the play_en transition, then the tick. Lower-priority events in the same cycle are discarded.
- Beat index range: ibeat never reaches len. It is always below LEN1 even after switching from track 1 to track 0, because every switch zeroes ibeat.
- Reset mid-operation: asynchronous return to the reset values. No done pulse is generated.

Decomposition:
- Shared package playback_pkg:
  - state encoding (IDLE=0, PLAY=1, PAUSE=2, GAP=3, DONE=4; 3 bits);
  - default LEN0, LEN1 and TICK_DIV constants;
  - SILENCE_DIV constant (50000000) used by the note path.
- One sub-module, beat_tick_gen: parameter TICK_DIV; ports clk, rst, run, clear, tick.
- The FSM, beat counter and gap counter stay in playback_sequencer.

Test Plan:
1. TICK_DIV=4, LEN0=8. Release rst, track_sel=0, play_en=1. ibeat steps 0..7, one step every 4 cycles. At the tick with ibeat=7 and repeat_en=0, done pulses once, the state is DONE, silence=1 and ibeat=0.
2. Same setup with repeat_en=1 and GAP_BEATS=2. After ibeat 7: silence=1 for exactly 8 cycles (2 beats), then PLAY with ibeat=0 and silence=0.
3. Pause at ibeat=3 with tick_cnt=2. Hold play_en=0 for 20 cycles: ibeat stays 3 and no beat_tick occurs. Set play_en=1: the next tick arrives after 2 cycles and ibeat=4.
4. In PLAY, track 0, ibeat=5: pulse next_pulse. The next cycle shows track=1, ibeat=0, state PLAY. Track 1 then runs to LEN1-1 before ending.
5. track_sel toggles and next_pulse fires in the same cycle: track follows track_sel only, and next_pulse is dropped.
6. Assert rst mid-GAP, asynchronous to clk. All outputs return to their reset values before the next clk edge, and done stays 0.
